// File: rtl/polirv_dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polirv_dmem_pkg : shared types and widths for the PoliRV data memory     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package polirv_dmem_pkg;

    localparam int DMEM_DATA_W     = 64;
    localparam int DMEM_WORD_BYTES = 8;
    localparam int DMEM_LANE_W     = $clog2(DMEM_WORD_BYTES);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/polirv_dmem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polirv_dmem_loader : little-endian byte-to-word assembler for boot load  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module polirv_dmem_loader
    import polirv_dmem_pkg::*;
#(
    parameter int D_ADDR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_active,
    input  logic                   i_start,
    input  logic                   i_valid,
    input  logic [7:0]             i_byte,
    input  logic                   i_done,
    output logic                   o_wr_en,
    output logic [D_ADDR_BITS-1:0] o_wr_addr,
    output logic [DMEM_DATA_W-1:0] o_wr_data
);

    localparam logic [DMEM_LANE_W-1:0] c_last_lane = DMEM_LANE_W'(DMEM_WORD_BYTES - 1);

    logic [DMEM_LANE_W-1:0] r_byte_cnt;
    logic [DMEM_DATA_W-1:0] r_lanes;
    logic [D_ADDR_BITS-1:0] r_ld_ptr;

    logic                   w_take;
    logic                   w_commit;
    logic                   w_flush;
    logic [DMEM_LANE_W-1:0] w_cnt_after;
    logic [DMEM_DATA_W-1:0] w_word;

    // A restart in the same cycle discards whatever byte arrives with it.
    assign w_take      = i_active & i_valid & ~i_start;
    assign w_cnt_after = r_byte_cnt + {{(DMEM_LANE_W-1){1'b0}}, w_take};
    assign w_commit    = w_take & (r_byte_cnt == c_last_lane);
    assign w_flush     = i_active & i_done & ~i_start & (w_cnt_after != '0);

    always_comb begin
        w_word = r_lanes;
        if (w_take) begin
            w_word[{r_byte_cnt, 3'b000} +: 8] = i_byte;
        end
    end

    assign o_wr_en   = w_commit | w_flush;
    assign o_wr_addr = r_ld_ptr;
    assign o_wr_data = w_word;

    // Lanes are zeroed after every commit so a flushed partial word has clean upper bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_lanes    <= '0;
            r_ld_ptr   <= '0;
        end else if (i_start) begin
            r_byte_cnt <= '0;
            r_lanes    <= '0;
            r_ld_ptr   <= '0;
        end else if (i_active) begin
            if (w_commit) begin
                r_ld_ptr <= r_ld_ptr + D_ADDR_BITS'(1);
            end
            if (w_commit || i_done) begin
                r_lanes    <= '0;
                r_byte_cnt <= '0;
            end else begin
                r_lanes    <= w_word;
                r_byte_cnt <= w_cnt_after;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/polirv_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polirv_dmem : PoliRV data-memory responder with byte-stream loader;      |
// |   DMEM_CLEAR_ON_RESET_EN adds a zeroing sweep after reset.               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module polirv_dmem
    import polirv_dmem_pkg::*;
#(
    parameter int D_ADDR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_mem_we,
    input  logic [D_ADDR_BITS-1:0] d_mem_addr,
    inout  wire  [DMEM_DATA_W-1:0] d_mem_data,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_byte,
    input  logic                   ld_done,
    output logic                   ld_ready,
    output logic                   busy
);

    localparam int c_depth = 1 << D_ADDR_BITS;

    dmem_state_t            r_state;
    logic                   r_busy;
    logic                   r_ld_ready;
    logic [DMEM_DATA_W-1:0] r_mem [c_depth];

    logic                   w_start;
    logic                   w_drive;
    logic                   w_ld_wr_en;
    logic [D_ADDR_BITS-1:0] w_ld_wr_addr;
    logic [DMEM_DATA_W-1:0] w_ld_wr_data;
    logic                   w_mem_we;
    logic [D_ADDR_BITS-1:0] w_mem_waddr;
    logic [DMEM_DATA_W-1:0] w_mem_wdata;

`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [D_ADDR_BITS-1:0] r_sweep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep <= '0;
        end else if (r_state == CLEAR) begin
            r_sweep <= r_sweep + D_ADDR_BITS'(1);
        end
    end
`endif

    assign w_start = ld_start & (r_state != CLEAR);

    polirv_dmem_loader #(
        .D_ADDR_BITS (D_ADDR_BITS)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .i_active  (r_state == LOAD),
        .i_start   (w_start),
        .i_valid   (ld_valid),
        .i_byte    (ld_byte),
        .i_done    (ld_done),
        .o_wr_en   (w_ld_wr_en),
        .o_wr_addr (w_ld_wr_addr),
        .o_wr_data (w_ld_wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            r_state <= CLEAR;
            r_busy  <= 1'b1;
`else
            r_state <= RUN;
            r_busy  <= 1'b0;
`endif
            r_ld_ready <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (ld_start) begin
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!ld_start && ld_done) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b0;
                        r_ld_ready <= 1'b0;
                    end
                end
`ifdef DMEM_CLEAR_ON_RESET_EN
                CLEAR: begin
                    if (r_sweep == '1) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state    <= RUN;
                    r_busy     <= 1'b0;
                    r_ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // Exactly one writer owns the array port in each state.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = d_mem_addr;
        w_mem_wdata = d_mem_data;
        case (r_state)
            RUN: begin
                w_mem_we = d_mem_we;
            end
            LOAD: begin
                w_mem_we    = w_ld_wr_en;
                w_mem_waddr = w_ld_wr_addr;
                w_mem_wdata = w_ld_wr_data;
            end
`ifdef DMEM_CLEAR_ON_RESET_EN
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_sweep;
                w_mem_wdata = '0;
            end
`endif
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
        if (rst) begin
            w_mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign w_drive    = (r_state == RUN) & ~d_mem_we & ~rst;
    assign d_mem_data = w_drive ? r_mem[d_mem_addr] : {DMEM_DATA_W{1'bz}};

    assign ld_ready = r_ld_ready;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_polirv_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_polirv_dmem : randomized bench for polirv_dmem with a word-level      |
// |   memory model; honours DMEM_CLEAR_ON_RESET_EN.                          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_polirv_dmem;
    import polirv_dmem_pkg::*;

    localparam int c_aw    = 2;
    localparam int c_depth = 1 << c_aw;

    logic            clk = 1'b0;
    logic            rst;
    logic            d_mem_we;
    logic [c_aw-1:0] d_mem_addr;
    logic            ld_start;
    logic            ld_valid;
    logic [7:0]      ld_byte;
    logic            ld_done;
    logic            ld_ready;
    logic            busy;
    logic [63:0]     tb_drv;
    logic            tb_oe;
    wire  [63:0]     d_mem_data;

    assign d_mem_data = tb_oe ? tb_drv : {64{1'bz}};

    logic [63:0] mdl_mem   [c_depth];
    bit          mdl_known [c_depth];
    logic [7:0]  bq [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    polirv_dmem #(
        .D_ADDR_BITS (c_aw)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d_mem_we   (d_mem_we),
        .d_mem_addr (d_mem_addr),
        .d_mem_data (d_mem_data),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_done    (ld_done),
        .ld_ready   (ld_ready),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        d_mem_we = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        ld_byte  = 8'h00;
        tb_oe    = 1'b0;
        tb_drv   = 64'h0;
    endtask

    // Every task below starts just after a falling edge and consumes one or more full cycles.
    task automatic core_read(input logic [c_aw-1:0] addr);
        idle_inputs();
        d_mem_addr = addr;
        #2;
        if (mdl_known[addr]) check_eq("rd", d_mem_data, mdl_mem[addr]);
        @(negedge clk);
    endtask

    task automatic core_read_exp(input logic [c_aw-1:0] addr, input logic [63:0] exp);
        idle_inputs();
        d_mem_addr = addr;
        #2;
        check_eq("rd_fixed", d_mem_data, exp);
        @(negedge clk);
    endtask

    task automatic core_write(input logic [c_aw-1:0] addr, input logic [63:0] data);
        idle_inputs();
        d_mem_we   = 1'b1;
        d_mem_addr = addr;
        tb_oe      = 1'b1;
        tb_drv     = data;
        #2;
        check_eq("wr_bus", d_mem_data, data);
        @(negedge clk);
        mdl_mem[addr]   = data;
        mdl_known[addr] = 1'b1;
    endtask

    task automatic read_all();
        for (int a = 0; a < c_depth; a++) core_read(c_aw'(a));
    endtask

    // poke: 0 none, 1 core write of 0x1234 to addr 2, 2 random core traffic
    task automatic load_stream(input int restart_at, input bit done_with_last, input int poke);
        int          first;
        int          n;
        logic [63:0] word;
        first = 0;
        idle_inputs();
        ld_start = 1'b1;
        #2;
        @(negedge clk);
        idle_inputs();
        #2;
        check_eq("ld_busy", 64'(busy), 64'd1);
        check_eq("ld_rdy_enter", 64'(ld_ready), 64'd1);
        for (int i = 0; i < bq.size(); i++) begin
            if (i == restart_at) begin
                idle_inputs();
                ld_start = 1'b1;
                #2;
                @(negedge clk);
                first = i;
            end
            idle_inputs();
            ld_valid = 1'b1;
            ld_byte  = bq[i];
            ld_done  = done_with_last && (i == bq.size() - 1);
            tb_oe    = 1'b1;
            if (poke == 1) begin
                d_mem_we   = 1'b1;
                d_mem_addr = 2'd2;
                tb_drv     = 64'h1234;
            end else if (poke == 2) begin
                d_mem_we   = 1'($urandom_range(0, 1));
                d_mem_addr = c_aw'($urandom_range(0, c_depth - 1));
            end
            #2;
            check_eq("ld_ready", 64'(ld_ready), 64'd1);
            check_eq("ld_bus", d_mem_data, tb_drv);
            @(negedge clk);
        end
        if (!done_with_last) begin
            idle_inputs();
            ld_done = 1'b1;
            #2;
            @(negedge clk);
        end
        idle_inputs();
        #2;
        check_eq("ld_exit_busy", 64'(busy), 64'd0);
        check_eq("ld_exit_rdy", 64'(ld_ready), 64'd0);
        n = bq.size() - first;
        for (int w = 0; 8 * w < n; w++) begin
            word = 64'h0;
            for (int b = 0; b < 8; b++) begin
                if (8 * w + b < n) word[8*b +: 8] = bq[first + 8*w + b];
            end
            mdl_mem[w % c_depth]   = word;
            mdl_known[w % c_depth] = 1'b1;
        end
        @(negedge clk);
    endtask

`ifdef DMEM_CLEAR_ON_RESET_EN
    task automatic sweep_check();
        for (int i = 0; i < c_depth; i++) begin
            #2;
            check_eq("clr_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        #2;
        check_eq("clr_done", 64'(busy), 64'd0);
        for (int a = 0; a < c_depth; a++) begin
            mdl_mem[a]   = 64'h0;
            mdl_known[a] = 1'b1;
        end
        @(negedge clk);
    endtask
`endif

    task automatic pulse_reset();
        idle_inputs();
        rst    = 1'b1;
        tb_oe  = 1'b1;
        tb_drv = 64'h0;
        #2;
        check_eq("rst_rdy", 64'(ld_ready), 64'd0);
        check_eq("rst_bus", d_mem_data, 64'h0);
`ifdef DMEM_CLEAR_ON_RESET_EN
        check_eq("rst_busy", 64'(busy), 64'd1);
`else
        check_eq("rst_busy", 64'(busy), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
`ifdef DMEM_CLEAR_ON_RESET_EN
        sweep_check();
`else
        #2;
        check_eq("run_busy", 64'(busy), 64'd0);
        @(negedge clk);
`endif
    endtask

    initial begin
        int n;
        int ra;
        for (int a = 0; a < c_depth; a++) mdl_known[a] = 1'b0;
        idle_inputs();
        d_mem_addr = '0;
        rst        = 1'b1;
        @(negedge clk);
        pulse_reset();
        read_all();

        // Sixteen-byte load, two full words
        bq.delete();
        for (int i = 1; i <= 16; i++) bq.push_back(8'(i));
        load_stream(-1, 1'b0, 0);
        core_read_exp(2'd0, 64'h0807060504030201);
        core_read_exp(2'd1, 64'h100F0E0D0C0B0A09);

        // Partial word flushed with the last byte
        bq.delete();
        bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC);
        load_stream(-1, 1'b1, 0);
        core_read_exp(2'd0, 64'h0000000000CCBBAA);

        // Core write then same-cycle read
        core_write(2'd1, 64'hDEADBEEF_CAFEF00D);
        core_read_exp(2'd1, 64'hDEADBEEF_CAFEF00D);
        core_write(2'd2, 64'h5555_AAAA_0F0F_F0F0);

        // Core writes to addr 2 during LOAD must be ignored
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        load_stream(-1, 1'b0, 1);
        core_read_exp(2'd2, 64'h5555_AAAA_0F0F_F0F0);
        read_all();

        // Five words wrap the pointer back to address 0
        bq.delete();
        for (int i = 0; i < 40; i++) bq.push_back(8'($urandom));
        load_stream(-1, 1'b1, 2);
        read_all();

        // Restart mid-word discards the partial
        bq.delete();
        for (int i = 0; i < 13; i++) bq.push_back(8'($urandom));
        load_stream(5, 1'b0, 0);
        read_all();

        // Reset in the middle of a load
        idle_inputs();
        ld_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
            @(negedge clk);
        end
        pulse_reset();
        read_all();

`ifdef DMEM_CLEAR_ON_RESET_EN
        // Reset during the sweep restarts it from address 0
        bq.delete();
        for (int i = 0; i < 32; i++) bq.push_back(8'($urandom));
        load_stream(-1, 1'b0, 0);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset();
        read_all();
`endif

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: core_write(c_aw'($urandom_range(0, c_depth - 1)), {$urandom, $urandom});
                1, 2: core_read(c_aw'($urandom_range(0, c_depth - 1)));
                default: begin
                    bq.delete();
                    n = $urandom_range(1, 20);
                    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
                    ra = -1;
                    if (n > 2 && $urandom_range(0, 3) == 0) ra = $urandom_range(1, n - 1);
                    load_stream(ra, 1'($urandom_range(0, 1)), 2);
                    read_all();
                end
            endcase
        end
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/polirv_dmem.md
# polirv_dmem

Data-memory responder for the PoliRV core: the target end of the processor's `d_mem_*` interface. It holds a 2^d_addr_bits × 64-bit word array, drives `d_mem_data` on reads, and captures it on writes. A byte-stream loader port lets a testbench or boot host fill memory before the core runs. An optional post-reset clear sweep zeroes every word.

## Interface
- `d_addr_bits`, 6, word-address width; depth = 2^d_addr_bits words of 64 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `d_mem_we` input 1: core write enable.
- `d_mem_addr` input d_addr_bits: core word address.
- `d_mem_data` inout 64: shared data bus; this block drives it only on reads.
- `ld_start` input 1: pulse; enter LOAD, word pointer and byte counter to 0.
- `ld_valid` input 1: loader byte valid.
- `ld_byte` input 8: loader byte, little-endian within a word.
- `ld_done` input 1: pulse; flush any partial word, return to RUN.
- `ld_ready` output 1: loader byte accepted this cycle when high with `ld_valid`.
- `busy` output 1: high in LOAD or CLEAR; core accesses are not serviced.

## Operation
- States: CLEAR, RUN, LOAD.
- RUN:
  - `d_mem_we`=0: drive `mem[d_mem_addr]` onto `d_mem_data` combinationally (same-cycle read).
  - `d_mem_we`=1: release the bus (high-Z); write `d_mem_data` to `mem[d_mem_addr]` at the rising edge.
  - `ld_start`=1 → LOAD. A core write in the same cycle is still performed.
- LOAD:
  - Bus always high-Z; core writes are ignored.
  - `ld_ready`=1.
  - Each accepted byte goes into lane `byte_cnt` (bits 8·k+7:8·k) of the assembly register; `byte_cnt` increments mod 8.
  - On the 8th byte, the assembled word is written to `mem[ld_ptr]`, then `ld_ptr` increments. `ld_ptr` wraps from 2^d_addr_bits−1 to 0.
  - `ld_done`:
    - If `byte_cnt`≠0 after this cycle's byte, write the partial word with the unfilled upper lanes zero, then go to RUN.
    - If `byte_cnt`=0, go to RUN directly.
    - A byte and `ld_done` in the same cycle: the byte is taken first, then the flush.
  - `ld_start` in LOAD: restart with `ld_ptr`=0 and `byte_cnt`=0; the partial word is discarded.
  - `ld_start` and `ld_done` in the same cycle: `ld_start` wins.
- CLEAR: a sweep counter writes 0 to one word per cycle from address 0 upward. After the last address, go to RUN. `ld_start` is ignored.
- Reset mid-operation:
  - State goes to CLEAR (macro set) or RUN (macro unset).
  - `ld_ptr`, `byte_cnt`, the assembly register and the sweep counter go to 0.
  - Array contents are not touched by reset itself.

## Timing
- Reset values:
  - `ld_ready`=0.
  - `d_mem_data` high-Z.
  - `busy`=1 with `DMEM_CLEAR_ON_RESET_EN` defined, otherwise 0.
- Read latency: 0 cycles (combinational from address). Write latency: 1 edge.
- LOAD throughput: 1 byte per cycle, so a full word is committed on the edge that accepts byte 8.
- `busy` is registered, asserted from the edge entering LOAD/CLEAR through the edge leaving it.
- The CLEAR sweep takes exactly 2^d_addr_bits cycles after `rst` deasserts. RUN starts on the next edge.

## Configuration
- `DMEM_CLEAR_ON_RESET_EN` defined:
  - Reset enters CLEAR, and `busy` is held for 2^d_addr_bits cycles.
  - Every word reads 0 afterwards.
- `DMEM_CLEAR_ON_RESET_EN` undefined:
  - Reset enters RUN directly and `busy`=0.
  - Contents are uninitialised (X in simulation).
  - The CLEAR state and sweep counter are not compiled.

## Structure
- Package `polirv_dmem_pkg`:
  - State enum {CLEAR, RUN, LOAD}.
  - `DMEM_DATA_W`=64.
  - `DMEM_WORD_BYTES`=8.
- Sub-module `polirv_dmem_loader`: byte assembler containing `byte_cnt`, the lane register, `ld_ptr`, and the word-commit/flush strobes. The top holds the array, the FSM and the bus tristate.

## Test plan
- Load then read: stream bytes 0x01..0x10 (`ld_start`, 16 `ld_valid` cycles, `ld_done`). Then core read addr 0 → 0x0807060504030201; addr 1 → 0x100F0E0D0C0B0A09.
- Partial flush: `ld_start`, 3 bytes 0xAA,0xBB,0xCC, `ld_done` → `mem[0]`=0x0000000000CCBBAA; `busy` falls the next cycle.
- Core write/read and tristate: write 0xDEADBEEF_CAFEF00D to addr 5. Next cycle, with `d_mem_we`=0 and addr 5, `d_mem_data` = that value. While `d_mem_we`=1 the block drives Z.
- LOAD blocks core: in LOAD, core write 0x1234 to addr 2 → `mem[2]` unchanged; bus Z throughout.
- Pointer wrap: with d_addr_bits=2, load 5 words → word 5 overwrites `mem[0]`.
- With `DMEM_CLEAR_ON_RESET_EN`: pulse `rst` after a load → `busy`=1 for exactly 4 cycles (d_addr_bits=2); then all reads are 0. A reset pulse mid-sweep restarts the sweep at address 0.
